// File: rtl/hb_decim_x2_poly.sv
// Polyphase half-band decimate-by-2 FIR for I/Q sample pairs.
// Define HB_DECIM_COEF_LOAD_EN to add the shadow/commit runtime coefficient path.
module hb_decim_x2_poly #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned COEF_WIDTH = 18,
   parameter int unsigned NUM_COEF   = 4,
   parameter logic [NUM_COEF*COEF_WIDTH-1:0] COEF_INIT =
      {18'h13462, 18'h3BE4D, 18'h00EEA, 18'h3FE26}
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic [WIDTH-1:0]      i_inph_data,
   input  logic [WIDTH-1:0]      i_quad_data,
   input  logic                  i_valid,
   input  logic                  i_clear,
   input  logic                  i_coef_wr,
   input  logic [((NUM_COEF > 1) ? $clog2(NUM_COEF) : 1)-1:0] i_coef_addr,
   input  logic [COEF_WIDTH-1:0] i_coef_data,
   input  logic                  i_coef_commit,
   output logic [WIDTH-1:0]      o_inph_data,
   output logic [WIDTH-1:0]      o_quad_data,
   output logic                  o_valid
);

   localparam int ADDR_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
   localparam int LG     = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 0;
   localparam int PAD    = 1 << LG;
   localparam int TAPS   = 4 * NUM_COEF - 1;
   localparam int HIST   = TAPS - 1;
   localparam int CTR    = 2 * NUM_COEF - 1;
   localparam int PW     = WIDTH + 1;
   localparam int MW     = WIDTH + COEF_WIDTH + 1;
   localparam int AW     = MW + LG + 2;
   localparam int LAT    = 4 + LG;

   localparam logic signed [AW-1:0] RND     = AW'(1) << (COEF_WIDTH - 1);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic                         accept;
   logic                         fire;
   logic                         phase_q;
   logic signed [COEF_WIDTH-1:0] coef    [NUM_COEF];
   logic signed [WIDTH-1:0]      in_s    [2];
   logic signed [WIDTH-1:0]      dl_q    [2][HIST];
   logic signed [WIDTH-1:0]      win     [2][TAPS];
   logic signed [PW-1:0]         pa_d    [2][NUM_COEF];
   logic signed [PW-1:0]         pa_q    [2][NUM_COEF];
   logic signed [MW-1:0]         prod    [2][NUM_COEF];
   logic signed [WIDTH-1:0]      ctr_q   [2];
   logic signed [WIDTH-1:0]      ctr_p_q [2][LG+1];
   logic signed [AW-1:0]         tree_q  [2][LG+1][PAD];
   logic signed [AW-1:0]         acc_q   [2];
   logic signed [AW-1:0]         shr     [2];
   logic signed [WIDTH-1:0]      sat_d   [2];
   logic signed [WIDTH-1:0]      sat_q   [2];
   logic [LAT:0]                 vld_q;

   assign in_s[0] = i_inph_data;
   assign in_s[1] = i_quad_data;
   assign accept  = i_valid && !i_clear;
   assign fire    = accept && phase_q;

`ifdef HB_DECIM_COEF_LOAD_EN
   logic signed [COEF_WIDTH-1:0] shadow_q [NUM_COEF];
   logic signed [COEF_WIDTH-1:0] shadow_d [NUM_COEF];
   logic signed [COEF_WIDTH-1:0] active_q [NUM_COEF];

   // The commit copies shadow_d so a same-cycle write is included.
   always_comb begin
      shadow_d = shadow_q;
      if (i_coef_wr && (int'(i_coef_addr) < int'(NUM_COEF))) begin
         shadow_d[i_coef_addr] = i_coef_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < NUM_COEF; k++) begin
            shadow_q[k] <= COEF_INIT[k*COEF_WIDTH +: COEF_WIDTH];
            active_q[k] <= COEF_INIT[k*COEF_WIDTH +: COEF_WIDTH];
         end
      end else begin
         shadow_q <= shadow_d;
         if (i_coef_commit) begin
            active_q <= shadow_d;
         end
      end
   end

   always_comb begin
      coef = active_q;
   end
`else
   logic unused_coef_if;
   assign unused_coef_if = ^{i_coef_wr, i_coef_addr, i_coef_data, i_coef_commit};

   always_comb begin
      for (int k = 0; k < NUM_COEF; k++) begin
         coef[k] = COEF_INIT[k*COEF_WIDTH +: COEF_WIDTH];
      end
   end
`endif

   // Sample history and phase; both freeze while i_valid is low.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_q <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < HIST; j++) begin
               dl_q[c][j] <= '0;
            end
         end
      end else if (i_clear) begin
         phase_q <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < HIST; j++) begin
               dl_q[c][j] <= '0;
            end
         end
      end else if (accept) begin
         phase_q <= ~phase_q;
         for (int c = 0; c < 2; c++) begin
            dl_q[c][0] <= in_s[c];
            for (int j = 1; j < HIST; j++) begin
               dl_q[c][j] <= dl_q[c][j-1];
            end
         end
      end
   end

   // win[c][j] is x[n-j] where x[n] is the sample on the input this cycle.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         win[c][0] = in_s[c];
         for (int j = 1; j < TAPS; j++) begin
            win[c][j] = dl_q[c][j-1];
         end
         for (int k = 0; k < NUM_COEF; k++) begin
            pa_d[c][k] = PW'(win[c][2*k]) + PW'(win[c][TAPS-1-2*k]);
         end
      end
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < NUM_COEF; k++) begin
            prod[c][k] = MW'(pa_q[c][k]) * MW'(coef[k]);
         end
      end
   end

   // Snapshot of the symmetric pairs, taken only on odd (output) samples.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int c = 0; c < 2; c++) begin
            ctr_q[c] <= '0;
            for (int k = 0; k < NUM_COEF; k++) begin
               pa_q[c][k] <= '0;
            end
         end
      end else if (fire) begin
         for (int c = 0; c < 2; c++) begin
            ctr_q[c] <= win[c][CTR];
            for (int k = 0; k < NUM_COEF; k++) begin
               pa_q[c][k] <= pa_d[c][k];
            end
         end
      end
   end

   // Free-running multiply / adder-tree / round pipeline; vld_q marks live slots.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int c = 0; c < 2; c++) begin
            acc_q[c] <= '0;
            sat_q[c] <= '0;
            for (int l = 0; l <= LG; l++) begin
               ctr_p_q[c][l] <= '0;
               for (int i = 0; i < PAD; i++) begin
                  tree_q[c][l][i] <= '0;
               end
            end
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            ctr_p_q[c][0] <= ctr_q[c];
            for (int l = 1; l <= LG; l++) begin
               ctr_p_q[c][l] <= ctr_p_q[c][l-1];
            end
            for (int i = 0; i < NUM_COEF; i++) begin
               tree_q[c][0][i] <= AW'(prod[c][i]);
            end
            for (int i = NUM_COEF; i < PAD; i++) begin
               tree_q[c][0][i] <= '0;
            end
            for (int l = 1; l <= LG; l++) begin
               for (int i = 0; i < (PAD >> l); i++) begin
                  tree_q[c][l][i] <= tree_q[c][l-1][2*i] + tree_q[c][l-1][2*i+1];
               end
               for (int i = (PAD >> l); i < PAD; i++) begin
                  tree_q[c][l][i] <= '0;
               end
            end
            acc_q[c] <= tree_q[c][LG][0] + (AW'(ctr_p_q[c][LG]) <<< (COEF_WIDTH - 1)) + RND;
            sat_q[c] <= sat_d[c];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         shr[c] = acc_q[c] >>> COEF_WIDTH;
         sat_d[c] = shr[c][WIDTH-1:0];
         if (shr[c] > SAT_MAX) begin
            sat_d[c] = SAT_MAX[WIDTH-1:0];
         end else if (shr[c] < SAT_MIN) begin
            sat_d[c] = SAT_MIN[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_q       <= '0;
         o_inph_data <= '0;
         o_quad_data <= '0;
      end else begin
         if (i_clear) begin
            vld_q <= '0;
         end else begin
            vld_q <= {vld_q[LAT-1:0], fire};
         end
         if (vld_q[LAT-1] && !i_clear) begin
            o_inph_data <= sat_q[0];
            o_quad_data <= sat_q[1];
         end
      end
   end

   assign o_valid = vld_q[LAT];

endmodule

// File: tb/tb_hb_decim_x2_poly.sv
// Scoreboard bench for hb_decim_x2_poly: a direct-form reference model (or literal
// impulse table) pushes expected outputs with their due cycle; a monitor pops them.
`timescale 1ns/1ps
module tb_hb_decim_x2_poly;

   localparam int WIDTH      = 16;
   localparam int COEF_WIDTH = 18;
   localparam int NUM_COEF   = 4;
   localparam int TAPS       = 4 * NUM_COEF - 1;
   localparam int LAT        = 6;

   logic                         i_clock = 1'b0;
   logic                         i_reset_n = 1'b0;
   logic signed [WIDTH-1:0]      i_inph_data = '0;
   logic signed [WIDTH-1:0]      i_quad_data = '0;
   logic                         i_valid = 1'b0;
   logic                         i_clear = 1'b0;
   logic                         i_coef_wr = 1'b0;
   logic [1:0]                   i_coef_addr = '0;
   logic [COEF_WIDTH-1:0]        i_coef_data = '0;
   logic                         i_coef_commit = 1'b0;
   logic signed [WIDTH-1:0]      o_inph_data;
   logic signed [WIDTH-1:0]      o_quad_data;
   logic                         o_valid;

   hb_decim_x2_poly dut (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_inph_data   (i_inph_data),
      .i_quad_data   (i_quad_data),
      .i_valid       (i_valid),
      .i_clear       (i_clear),
      .i_coef_wr     (i_coef_wr),
      .i_coef_addr   (i_coef_addr),
      .i_coef_data   (i_coef_data),
      .i_coef_commit (i_coef_commit),
      .o_inph_data   (o_inph_data),
      .o_quad_data   (o_quad_data),
      .o_valid       (o_valid)
   );

   always #5 i_clock = ~i_clock;

   int cyc = 0;
   always @(posedge i_clock) cyc <= cyc + 1;

   typedef struct {
      int ei;
      int eq;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t ent;
   int   hi[$];
   int   hq[$];
   bit   use_tbl = 1'b0;
   int   tbl      [8]        = '{-30, 239, -1051, 4934, 4934, -1051, 239, -30};
   int   coef_def [NUM_COEF] = '{-474, 3818, -16819, 78946};
   int   coef_m   [NUM_COEF] = '{-474, 3818, -16819, 78946};
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Full 15-tap impulse response in direct form.
   function automatic longint h(input int j);
      if (j == 2 * NUM_COEF - 1) return longint'(1) <<< (COEF_WIDTH - 1);
      if ((j % 2) == 1) return 0;
      if (j < 2 * NUM_COEF - 1) return longint'(coef_m[j / 2]);
      return longint'(coef_m[(TAPS - 1 - j) / 2]);
   endfunction

   function automatic int model_y(input bit q);
      longint a;
      int     n;
      int     x;
      n = hi.size() - 1;
      a = longint'(1) <<< (COEF_WIDTH - 1);
      for (int j = 0; j < TAPS; j++) begin
         if (n - j >= 0) begin
            x = q ? hq[n - j] : hi[n - j];
            a += h(j) * longint'(x);
         end
      end
      a = a >>> COEF_WIDTH;
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      return int'(a);
   endfunction

   task automatic send(input int xi, input int xq);
      exp_t e;
      int   m;
      i_valid     = 1'b1;
      i_inph_data = xi[WIDTH-1:0];
      i_quad_data = xq[WIDTH-1:0];
      @(posedge i_clock);
      #1;
      i_valid = 1'b0;
      hi.push_back(xi);
      hq.push_back(xq);
      if ((hi.size() % 2) == 0) begin
         m = (hi.size() - 2) / 2;
         if (use_tbl) begin
            e.ei = (m < 8) ? tbl[m] : 0;
            e.eq = 0;
         end else begin
            e.ei = model_y(1'b0);
            e.eq = model_y(1'b1);
         end
         e.due = cyc + LAT;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   // The sample presented with i_clear must be ignored.
   task automatic clear_with_sample();
      i_clear     = 1'b1;
      i_valid     = 1'b1;
      i_inph_data = 16'sd5000;
      i_quad_data = -16'sd5000;
      @(posedge i_clock);
      #1;
      i_clear = 1'b0;
      i_valid = 1'b0;
      sb.delete();
      hi.delete();
      hq.delete();
   endtask

   task automatic coef_write(input int addr, input int data, input bit commit);
      i_coef_wr     = 1'b1;
      i_coef_addr   = 2'(addr);
      i_coef_data   = COEF_WIDTH'(data);
      i_coef_commit = commit;
      @(posedge i_clock);
      #1;
      i_coef_wr     = 1'b0;
      i_coef_commit = 1'b0;
   endtask

   task automatic drain();
      idle(LAT + 3);
      check("drain_empty", sb.size(), 0);
   endtask

   always @(negedge i_clock) begin
      if (o_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", o_valid, 1'b0);
         end else begin
            ent = sb.pop_front();
            check("latency", cyc, ent.due);
            check("y_inph", o_inph_data, ent.ei);
            check("y_quad", o_quad_data, ent.eq);
         end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
         check("missing_valid", o_valid, 1'b1);
         sb.delete(0);
      end
   end

   initial begin
      #1;
      check("rst_valid", o_valid, 1'b0);
      check("rst_inph", o_inph_data, 0);
      check("rst_quad", o_quad_data, 0);
      #11;
      i_reset_n = 1'b1;
      @(posedge i_clock);
      #1;

      // Impulse on I at x[1]; literal expected response.
      use_tbl = 1'b1;
      send(0, 0);
      send(16384, 0);
      for (int k = 0; k < 16; k++) send(0, 0);
      use_tbl = 1'b0;
      drain();

      // Ramp, then clear drops in-flight outputs; following centre impulse is phase 0.
      for (int k = 0; k < 6; k++) send(1000 * (k + 1), -700 * (k + 1));
      clear_with_sample();
      send(16384, -16384);
      for (int k = 0; k < 15; k++) send(0, 0);
      drain();

      // Continuous DC.
      clear_with_sample();
      for (int k = 0; k < 24; k++) send(10000, -10000);
      drain();
      check("dc_final_inph", o_inph_data, 9995);
      check("dc_final_quad", o_quad_data, -9995);

      // Sparse DC, one valid in three.
      clear_with_sample();
      for (int k = 0; k < 24; k++) begin
         send(10000, -10000);
         idle(2);
      end
      drain();
      check("sparse_final_inph", o_inph_data, 9995);
      check("sparse_final_quad", o_quad_data, -9995);

      // Coefficient load; the last write shares its cycle with the commit.
      coef_write(0, 131071, 1'b0);
      coef_write(1, 131071, 1'b0);
      coef_write(2, 131071, 1'b0);
      coef_write(3, 131071, 1'b1);
`ifdef HB_DECIM_COEF_LOAD_EN
      for (int k = 0; k < NUM_COEF; k++) coef_m[k] = 131071;
`endif
      clear_with_sample();
      for (int k = 0; k < 24; k++) send(32767, -32768);
      drain();
`ifdef HB_DECIM_COEF_LOAD_EN
      check("sat_final_inph", o_inph_data, 32767);
      check("sat_final_quad", o_quad_data, -32768);
`else
      check("nocoef_final_inph", o_inph_data, 32751);
      check("nocoef_final_quad", o_quad_data, -32752);
`endif

      // Asynchronous reset with outputs in flight.
      for (int k = 0; k < 4; k++) send(32767, -32768);
      #2;
      i_reset_n = 1'b0;
      sb.delete();
      hi.delete();
      hq.delete();
      coef_m = coef_def;
      #1;
      check("arst_valid", o_valid, 1'b0);
      check("arst_inph", o_inph_data, 0);
      check("arst_quad", o_quad_data, 0);
      #3;
      i_reset_n = 1'b1;
      @(posedge i_clock);
      #1;

      // Impulse again: coefficients must be back to their initial values.
      use_tbl = 1'b1;
      send(0, 0);
      send(16384, 0);
      for (int k = 0; k < 16; k++) send(0, 0);
      use_tbl = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
